// File: rtl/key_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// key_ctrl_pkg
// Shared definitions for the push-button conditioning / CPU step controller:
//   - ctrl_state_t : controller FSM states (HOLD, STEP, RUN)
//   - KEY_*        : roles of the debounced key indices
//   - cnt_width()  : width of a counter that holds the values 0..n-1
// -----------------------------------------------------------------------------
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,   // CPU held in reset
        STEP = 2'd1,   // CPU advances one cycle per step-key press
        RUN  = 2'd2    // CPU advances at the divided run rate
    } ctrl_state_t;

    localparam int KEY_RESET = 0;
    localparam int KEY_MODE  = 1;
    localparam int KEY_STEP  = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : key_ctrl_pkg

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button: 2-flop synchroniser (inverted so 1 = pressed), debounce
// counter and press-edge detector.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   key_raw   : raw active-low button, asynchronous to clk
//   key_level : debounced level, 1 = pressed
//   key_press : one-cycle pulse in the cycle after key_level rises
// -----------------------------------------------------------------------------
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;
    logic          pressed_sync;

    assign pressed_sync = ~sync2;

    // NOTE: all state updates use non-blocking assignments so every flop
    // samples the pre-edge value of the others (sync1 -> sync2 stays a pipe).
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser resets to the released level so leaving reset
            // never looks like a press.
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            key_level <= 1'b0;
            level_d   <= 1'b0;
            key_press <= 1'b0;
        end else begin
            sync1     <= key_raw;
            sync2     <= sync1;
            level_d   <= key_level;
            key_press <= key_level & ~level_d;

            // Counter only advances while the synced input disagrees with the
            // accepted level; any agreement restarts the qualification window.
            if (pressed_sync == key_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                key_level <= pressed_sync;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : key_debounce

// File: rtl/key_step_controller.sv
// -----------------------------------------------------------------------------
// key_step_controller
// Conditions the four board buttons and generates the CPU reset and advance
// strobe. KEY0 requests a CPU reset, KEY1 toggles run/step, KEY2 single-steps,
// KEY3 is exported only.
// Ports:
//   clk        : system clock (CLOCK_50 domain)
//   rst        : synchronous active-high reset
//   key_raw    : raw active-low buttons [3:0]
//   key_level  : debounced levels, 1 = pressed
//   key_press  : one-cycle press pulses
//   cpu_rst_n  : active-low reset to CPU and memory controller
//   cpu_clk_en : one-cycle advance strobe to the CPU
//   mode_run   : 1 = run mode, 0 = step mode
// -----------------------------------------------------------------------------
module key_step_controller
    import key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 5_000_000,
    parameter int RESET_HOLD      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic       cpu_rst_n,
    output logic       cpu_clk_en,
    output logic       mode_run
);

    localparam int HW = cnt_width(RESET_HOLD);
    localparam int PW = cnt_width(RUN_DIV);

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .key_raw  (key_raw[i]),
            .key_level(key_level[i]),
            .key_press(key_press[i])
        );
    end

    ctrl_state_t   state;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] presc_next;

    assign presc_next = (prescaler == PW'(RUN_DIV - 1)) ? '0 : prescaler + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            prescaler  <= '0;
            mode_run   <= 1'b0;
            cpu_rst_n  <= 1'b0;
            cpu_clk_en <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low every cycle so it can only ever be
            // a single-cycle pulse; branches below raise it when due.
            cpu_clk_en <= 1'b0;

            // Reset request outranks everything; mode_run is kept so the CPU
            // comes back in the mode it was in.
            if (key_press[KEY_RESET]) begin
                state     <= HOLD;
                hold_cnt  <= '0;
                cpu_rst_n <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        prescaler <= '0;   // run rate restarts from a full period
                        if (hold_cnt == HW'(RESET_HOLD - 1)) begin
                            state     <= mode_run ? RUN : STEP;
                            cpu_rst_n <= 1'b1;
                            hold_cnt  <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    STEP: begin
                        // A step coincident with a mode toggle is dropped.
                        if (key_press[KEY_MODE]) begin
                            mode_run  <= 1'b1;
                            prescaler <= '0;
                            state     <= RUN;
                        end else if (key_press[KEY_STEP]) begin
                            cpu_clk_en <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (key_press[KEY_MODE]) begin
                            mode_run <= 1'b0;
                            state    <= STEP;
                        end else begin
                            prescaler  <= presc_next;
                            cpu_clk_en <= (presc_next == PW'(RUN_DIV - 1));
                        end
                    end
                    default: begin
                        state     <= HOLD;
                        hold_cnt  <= '0;
                        cpu_rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : key_step_controller

// File: tb/tb_key_step_controller.sv
// -----------------------------------------------------------------------------
// tb_key_step_controller
// Directed scenarios followed by random key activity. Every stimulus cycle
// feeds a behavioural model whose expected outputs are queued; a monitor on
// the falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_key_step_controller;

    localparam int DEB = 4;
    localparam int RD  = 5;
    localparam int RH  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic       cpu_rst_n;
    logic       cpu_clk_en;
    logic       mode_run;

    always #5 clk = ~clk;

    key_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (RD),
        .RESET_HOLD     (RH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_level (key_level),
        .key_press (key_press),
        .cpu_rst_n (cpu_rst_n),
        .cpu_clk_en(cpu_clk_en),
        .mode_run  (mode_run)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keys: raw value delayed two samples, accepted after DEB consecutive
    // disagreeing samples, press reported one sample after the rise.
    // Controller: outside HOLD, RUN is exactly "mode is 1".
    bit [3:0] m_s1, m_s2, m_level, m_rose, m_press;
    int       m_run [4];
    bit       m_in_hold, m_mode, m_rstn, m_en;
    int       m_hold_elapsed, m_run_cycles;

    function automatic void model_step(input bit r, input logic [3:0] k);
        bit [3:0] pold;
        bit       lvl_old;
        if (r) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_level = '0; m_rose = '0; m_press = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_in_hold = 1; m_mode = 0; m_rstn = 0; m_en = 0;
            m_hold_elapsed = 0; m_run_cycles = 0;
            return;
        end
        pold = m_press;
        for (int i = 0; i < 4; i++) begin
            lvl_old = m_level[i];
            if (!m_s2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = !m_level[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_press[i] = m_rose[i];
            m_rose[i]  = m_level[i] && !lvl_old;
            m_s2[i]    = m_s1[i];
            m_s1[i]    = k[i];
        end
        m_en = 0;
        if (pold[0]) begin
            m_in_hold = 1; m_hold_elapsed = 0; m_rstn = 0;
        end else if (m_in_hold) begin
            m_hold_elapsed++;
            if (m_hold_elapsed == RH) begin
                m_in_hold = 0; m_rstn = 1; m_run_cycles = 0;
            end
        end else if (pold[1]) begin
            m_mode = !m_mode; m_run_cycles = 0;
        end else if (m_mode) begin
            m_run_cycles++;
            m_en = ((m_run_cycles % RD) == RD - 1);
        end else begin
            m_en = pold[2];
        end
    endfunction

    // ---------------- scoreboard + monitor ----------------
    logic [10:0] sb [$];
    logic [10:0] mon_exp, mon_act;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            mon_act = {key_level, key_press, cpu_rst_n, cpu_clk_en, mode_run};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard lvl/press/rstn/en/mode: got %b expected %b (t=%0t)",
                         mon_act, mon_exp, $time);
            end
            check("en_while_cpu_reset", int'(cpu_clk_en & ~cpu_rst_n), 0);
        end
    end

    // ---------------- stimulus + tallies ----------------
    int       tcyc;
    int       press_cnt [4];
    int       last_p [4];
    int       en_cnt;
    int       rstn_low_cnt;
    int       en_times [$];
    logic [3:0] lvl_or;

    task automatic clear_tally();
        for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; last_p[i] = -100; end
        en_cnt = 0; rstn_low_cnt = 0; lvl_or = '0;
        en_times.delete();
    endtask

    task automatic cycle(input bit r, input logic [3:0] k);
        rst     = r;
        key_raw = k;
        model_step(r, k);
        sb.push_back({m_level, m_press, m_rstn, m_en, m_mode});
        @(negedge clk);
        #1;
        tcyc++;
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) begin press_cnt[i]++; last_p[i] = tcyc; end
        end
        if (cpu_clk_en) begin en_cnt++; en_times.push_back(tcyc); end
        if (!cpu_rst_n) rstn_low_cnt++;
        lvl_or |= key_level;
    endtask

    task automatic run(input int n, input bit r, input logic [3:0] k);
        for (int i = 0; i < n; i++) cycle(r, k);
    endtask

    // First strobe strictly after cycle t, relative to t (-1 if none).
    function automatic int first_en_after(input int t);
        foreach (en_times[i]) if (en_times[i] > t) return en_times[i] - t;
        return -1;
    endfunction

    function automatic int en_in_window(input int lo, input int hi);
        int n = 0;
        foreach (en_times[i]) if (en_times[i] >= lo && en_times[i] <= hi) n++;
        return n;
    endfunction

    localparam logic [3:0] NONE = 4'b1111;

    initial begin
        int n;
        int p;
        tcyc = 0;
        clear_tally();

        // Reset state
        run(3, 1'b1, NONE);
        check("rst_key_level", key_level, 0);
        check("rst_key_press", key_press, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_cpu_clk_en", cpu_clk_en, 0);
        check("rst_mode_run", mode_run, 0);

        // Release: cpu_rst_n rises on the RH-th edge
        n = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, NONE);
            if (cpu_rst_n) begin n = i + 1; break; end
        end
        check("hold_release_edges", n, RH);
        clear_tally();
        run(6, 1'b0, NONE);
        check("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        check("idle_no_strobe", en_cnt, 0);
        check("idle_mode_step", mode_run, 0);

        // KEY2 glitch shorter than the debounce window
        clear_tally();
        run(3, 1'b0, 4'b1011);
        run(10, 1'b0, NONE);
        check("glitch_level", lvl_or[2], 0);
        check("glitch_press", press_cnt[2], 0);
        check("glitch_strobe", en_cnt, 0);

        // Clean KEY2 press: level after 2+DEB edges, one press, one step next cycle
        clear_tally();
        n = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b1011);
            if (key_level[2] && n < 0) n = i + 1;
        end
        run(12, 1'b0, NONE);
        check("press_latency", n, 2 + DEB);
        check("step_press_count", press_cnt[2], 1);
        check("step_strobe_count", en_cnt, 1);
        check("step_strobe_delay", first_en_after(last_p[2]), 1);

        // KEY1 in STEP -> RUN; strobes 5, 10, 15 cycles after the press pulse
        clear_tally();
        run(8, 1'b0, 4'b1101);
        run(22, 1'b0, NONE);
        p = last_p[1];
        check("run_mode_set", mode_run, 1);
        check("run_strobe_1", en_in_window(p + RD, p + RD), 1);
        check("run_strobe_2", en_in_window(p + 2 * RD, p + 2 * RD), 1);
        check("run_strobe_3", en_in_window(p + 3 * RD, p + 3 * RD), 1);
        check("run_strobe_only_those", en_in_window(p + 1, p + 3 * RD), 3);

        // KEY1 again: strobes stop
        clear_tally();
        run(8, 1'b0, 4'b1101);
        run(20, 1'b0, NONE);
        check("step_mode_back", mode_run, 0);
        check("no_strobe_after_toggle", en_in_window(last_p[1] + 1, tcyc), 0);

        // KEY0 in RUN: 3-cycle hold, back to RUN, first strobe RD after release
        run(8, 1'b0, 4'b1101);
        run(10, 1'b0, NONE);
        clear_tally();
        run(8, 1'b0, 4'b1110);
        run(14, 1'b0, NONE);
        p = last_p[0];
        check("key0_hold_cycles", rstn_low_cnt, RH);
        check("key0_no_strobe_in_hold", en_in_window(p + 1, p + RH), 0);
        check("key0_first_strobe", first_en_after(p), RH + RD);
        check("key0_mode_kept", mode_run, 1);

        // Back to STEP, then KEY1+KEY2 together: toggle wins, step dropped
        run(8, 1'b0, 4'b1101);
        run(10, 1'b0, NONE);
        clear_tally();
        run(8, 1'b0, 4'b1001);
        run(10, 1'b0, NONE);
        p = last_p[1];
        check("simul_same_cycle", last_p[2], p);
        check("simul_mode_run", mode_run, 1);
        check("simul_step_dropped", en_in_window(p + 1, p + RD - 1), 0);

        // Back to STEP, then KEY0+KEY1+KEY2: HOLD wins, mode unchanged
        run(8, 1'b0, 4'b1101);
        run(10, 1'b0, NONE);
        clear_tally();
        run(8, 1'b0, 4'b1000);
        run(8, 1'b0, NONE);
        check("triple_mode_kept", mode_run, 0);
        check("triple_hold", rstn_low_cnt, RH);
        check("triple_no_strobe", en_cnt, 0);

        // rst mid-operation in RUN with KEY3 debounce 2 counts in
        run(8, 1'b0, 4'b1101);
        run(10, 1'b0, NONE);
        check("pre_rst_run", mode_run, 1);
        run(4, 1'b0, 4'b0111);
        cycle(1'b1, NONE);
        check("midrst_level", key_level, 0);
        check("midrst_press", key_press, 0);
        check("midrst_cpu_rst_n", cpu_rst_n, 0);
        check("midrst_en", cpu_clk_en, 0);
        check("midrst_mode", mode_run, 0);
        clear_tally();
        run(12, 1'b0, NONE);
        check("midrst_no_key3_press", press_cnt[3], 0);

        // Random key activity, model-checked every cycle
        for (int s = 0; s < 70; s++) begin
            logic [3:0] k;
            k    = 4'($urandom_range(0, 15));
            k[0] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 40) == 0)
                cycle(1'b1, NONE);
            else
                run($urandom_range(1, 12), 1'b0, k);
        end
        run(12, 1'b0, NONE);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_step_controller
